instr_buffer: RTL and testbench

- Circular queue between the decode/dependency-tag stage and ROB/reservation-station dispatch.
- Accepts up to 4 decoded instruction records per cycle, oldest in slot 0.
- Presents up to 2 oldest records per cycle to dispatch.
- Reports free capacity, clamped to 4, which drives the fetch stage's num_fetch input.

---
 rtl/ib_pkg.sv | 21 ++
 rtl/ib_storage.sv | 34 +++
 rtl/instr_buffer.sv | 181 ++++++++++++++++++
 tb/tb_instr_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib_pkg.sv
// Shared types and widths for the instruction buffer.
// Record layout: {opcode, rt, ra, rb, a_dep, a_owner, b_dep, b_owner}.
package ib_pkg;

  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int TAG_W   = 4;
  localparam int ENTRY_W = 26;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             a_dep;
    logic [TAG_W-1:0] a_owner;
    logic             b_dep;
    logic [TAG_W-1:0] b_owner;
  } ib_entry_t;

endpackage

// File: rtl/ib_storage.sv
// Entry array: DEPTH x ENTRY_W, NWR write ports, NRD async read ports.
// Ports: clk, i_wr_en/i_wr_addr/i_wr_data, i_rd_addr -> o_rd_data.
module ib_storage
  import ib_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NWR   = 4,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR-1:0][AW-1:0]    i_wr_addr,
  input  ib_entry_t [NWR-1:0]       i_wr_data,
  input  logic [NRD-1:0][AW-1:0]    i_rd_addr,
  output ib_entry_t [NRD-1:0]       o_rd_data
);

  // Storage is intentionally not reset.
  ib_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NWR; k++) begin
      if (i_wr_en[k]) r_mem[i_wr_addr[k]] <= i_wr_data[k];
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      o_rd_data[i] = r_mem[i_rd_addr[i]];
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Circular decode->dispatch queue: 4 in, 2 out, sticky overflow_err.
// Define IB_BYPASS_EN to forward inputs to outputs when empty.
module instr_buffer
  import ib_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 4,
  parameter int DISP_W  = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [2:0]                      in_count,
  input  logic [FETCH_W-1:0][OPC_W-1:0]   in_opcode,
  input  logic [FETCH_W-1:0][REG_W-1:0]   in_rt,
  input  logic [FETCH_W-1:0][REG_W-1:0]   in_ra,
  input  logic [FETCH_W-1:0][REG_W-1:0]   in_rb,
  input  logic [FETCH_W-1:0]              in_a_dep,
  input  logic [FETCH_W-1:0]              in_b_dep,
  input  logic [FETCH_W-1:0][TAG_W-1:0]   in_a_owner,
  input  logic [FETCH_W-1:0][TAG_W-1:0]   in_b_owner,
  output logic [2:0]                      free_slots,
  output logic [DISP_W-1:0]               out_valid,
  output logic [DISP_W-1:0][OPC_W-1:0]    out_opcode,
  output logic [DISP_W-1:0][REG_W-1:0]    out_rt,
  output logic [DISP_W-1:0][REG_W-1:0]    out_ra,
  output logic [DISP_W-1:0][REG_W-1:0]    out_rb,
  output logic [DISP_W-1:0]               out_a_dep,
  output logic [DISP_W-1:0][TAG_W-1:0]    out_a_owner,
  output logic [DISP_W-1:0]               out_b_dep,
  output logic [DISP_W-1:0][TAG_W-1:0]    out_b_owner,
  input  logic [1:0]                      deq_count,
  output logic [CW-1:0]                   count,
  output logic                            overflow_err
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [2:0]    r_free;
  logic          r_err;

  ib_entry_t [FETCH_W-1:0]         w_in;
  ib_entry_t [DISP_W-1:0]          w_rd;
  ib_entry_t [DISP_W-1:0]          w_out;
  logic [FETCH_W-1:0]              w_wr_en;
  logic [FETCH_W-1:0][AW-1:0]      w_wr_addr;
  ib_entry_t [FETCH_W-1:0]         w_wr_data;
  logic [DISP_W-1:0][AW-1:0]       w_rd_addr;

  logic          w_bypass;
  logic          w_wr_ok;
  logic [1:0]    w_nvld;
  logic          w_deq_err;
  logic [1:0]    w_deq;
  logic [1:0]    w_skip;
  logic [1:0]    w_pop;
  logic [2:0]    w_push;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_room;
  logic [2:0]    w_free_nxt;

`ifdef IB_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      w_in[k].opcode  = in_opcode[k];
      w_in[k].rt      = in_rt[k];
      w_in[k].ra      = in_ra[k];
      w_in[k].rb      = in_rb[k];
      w_in[k].a_dep   = in_a_dep[k];
      w_in[k].a_owner = in_a_owner[k];
      w_in[k].b_dep   = in_b_dep[k];
      w_in[k].b_owner = in_b_owner[k];
    end
  end

  // Enqueue check uses the registered free count, not a same-cycle credit.
  assign w_wr_ok = (in_count <= r_free);

  // Records visible to dispatch this cycle (0..2).
  always_comb begin
    w_nvld = 2'd0;
    if (w_bypass) begin
      if (w_wr_ok) begin
        w_nvld = (in_count >= 3'd2) ? 2'd2 : in_count[1:0];
      end
    end else begin
      w_nvld = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    end
  end

  assign w_deq_err = (deq_count > w_nvld);
  assign w_deq     = w_deq_err ? w_nvld : deq_count;
  // Bypassed records already consumed are skipped, never stored.
  assign w_skip    = w_bypass ? w_deq : 2'd0;
  assign w_pop     = w_bypass ? 2'd0 : w_deq;
  assign w_push    = w_wr_ok ? (in_count - {1'b0, w_skip}) : 3'd0;

  assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room     = CW'(DEPTH) - w_cnt_nxt;
  assign w_free_nxt = (w_room >= CW'(4)) ? 3'd4 : w_room[2:0];

  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      w_wr_en[k]   = (3'(k) < w_push);
      w_wr_addr[k] = r_tail + AW'(k);
      w_wr_data[k] = w_in[k];
      for (int s = 0; s < FETCH_W; s++) begin
        if (s == k + int'(w_skip)) w_wr_data[k] = w_in[s];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DISP_W; i++) begin
      w_rd_addr[i] = r_head + AW'(i);
    end
  end

  ib_storage #(
    .DEPTH (DEPTH),
    .NWR   (FETCH_W),
    .NRD   (DISP_W)
  ) u_storage (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_free  <= 3'd4;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_free  <= 3'd4;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push);
      r_count <= w_cnt_nxt;
      r_free  <= w_free_nxt;
      if (!w_wr_ok || w_deq_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DISP_W; i++) begin
      w_out[i]       = w_bypass ? w_in[i] : w_rd[i];
      out_opcode[i]  = w_out[i].opcode;
      out_rt[i]      = w_out[i].rt;
      out_ra[i]      = w_out[i].ra;
      out_rb[i]      = w_out[i].rb;
      out_a_dep[i]   = w_out[i].a_dep;
      out_a_owner[i] = w_out[i].a_owner;
      out_b_dep[i]   = w_out[i].b_dep;
      out_b_owner[i] = w_out[i].b_owner;
    end
  end

  // Thermometer: 00, 01 or 11.
  assign out_valid    = {w_nvld[1], |w_nvld};
  assign free_slots   = r_free;
  assign count        = r_count;
  assign overflow_err = r_err;

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer.
// Records are queued when driven and compared when dispatched.
module tb_instr_buffer;
  import ib_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      in_count = 3'd0;
  logic [1:0]      deq_count = 2'd0;
  logic [3:0][3:0] in_opcode, in_rt, in_ra, in_rb;
  logic [3:0][3:0] in_a_owner, in_b_owner;
  logic [3:0]      in_a_dep, in_b_dep;
  logic [2:0]      free_slots;
  logic [1:0]      out_valid;
  logic [1:0][3:0] out_opcode, out_rt, out_ra, out_rb;
  logic [1:0][3:0] out_a_owner, out_b_owner;
  logic [1:0]      out_a_dep, out_b_dep;
  logic [4:0]      count;
  logic            overflow_err;

  instr_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_count     (in_count),
    .in_opcode    (in_opcode),
    .in_rt        (in_rt),
    .in_ra        (in_ra),
    .in_rb        (in_rb),
    .in_a_dep     (in_a_dep),
    .in_b_dep     (in_b_dep),
    .in_a_owner   (in_a_owner),
    .in_b_owner   (in_b_owner),
    .free_slots   (free_slots),
    .out_valid    (out_valid),
    .out_opcode   (out_opcode),
    .out_rt       (out_rt),
    .out_ra       (out_ra),
    .out_rb       (out_rb),
    .out_a_dep    (out_a_dep),
    .out_a_owner  (out_a_owner),
    .out_b_dep    (out_b_dep),
    .out_b_owner  (out_b_owner),
    .deq_count    (deq_count),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

`ifdef IB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ib_entry_t  sb[$];
  logic [3:0] pop_log[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] op_ctr = 4'd1;
  int         m_free = 4;
  bit         m_err = 1'b0;

  function automatic ib_entry_t out_rec(input int i);
    ib_entry_t e;
    e.opcode  = out_opcode[i];
    e.rt      = out_rt[i];
    e.ra      = out_ra[i];
    e.rb      = out_rb[i];
    e.a_dep   = out_a_dep[i];
    e.a_owner = out_a_owner[i];
    e.b_dep   = out_b_dep[i];
    e.b_owner = out_b_owner[i];
    return e;
  endfunction

  // One clock of stimulus; dispatched records are checked
  // against the scoreboard front before the edge.
  task automatic cycle(input int n_in, input int n_deq, input bit fl);
    ib_entry_t  recs[4];
    ib_entry_t  got;
    ib_entry_t  tmp;
    int         vis, nd;
    bit         ok, byp;
    logic [1:0] ev;
    ok  = (n_in <= m_free);
    byp = BYP && (sb.size() == 0) && !fl;
    for (int k = 0; k < 4; k++) begin
      recs[k] = ib_entry_t'($urandom);
      if (k < n_in && ok && !fl) begin
        recs[k].opcode = op_ctr;
        op_ctr = op_ctr + 4'd1;
      end
      in_opcode[k]  = recs[k].opcode;
      in_rt[k]      = recs[k].rt;
      in_ra[k]      = recs[k].ra;
      in_rb[k]      = recs[k].rb;
      in_a_dep[k]   = recs[k].a_dep;
      in_a_owner[k] = recs[k].a_owner;
      in_b_dep[k]   = recs[k].b_dep;
      in_b_owner[k] = recs[k].b_owner;
    end
    in_count  = 3'(n_in);
    deq_count = 2'(n_deq);
    flush     = fl;
    #1;
    if (byp && ok)
      for (int k = 0; k < n_in; k++) sb.push_back(recs[k]);
    vis = (sb.size() >= 2) ? 2 : sb.size();
    ev  = (vis == 2) ? 2'b11 : (vis == 1) ? 2'b01 : 2'b00;
    n_chk++;
    if (out_valid !== ev)
      $display("FAIL out_valid got=%b exp=%b", out_valid, ev);
    else n_pass++;
    nd = fl ? 0 : ((n_deq < vis) ? n_deq : vis);
    for (int i = 0; i < nd; i++) begin
      got = out_rec(i);
      n_chk++;
      if (got !== sb[i])
        $display("FAIL sb_rec%0d got=%h exp=%h", i, got, sb[i]);
      else n_pass++;
    end
    if (!fl && (!ok || n_deq > vis)) m_err = 1'b1;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      for (int i = 0; i < nd; i++) begin
        tmp = sb.pop_front();
        pop_log.push_back(tmp.opcode);
      end
      if (!byp && ok)
        for (int k = 0; k < n_in; k++) sb.push_back(recs[k]);
    end
    m_free = (16 - sb.size() >= 4) ? 4 : 16 - sb.size();
    in_count  = 3'd0;
    deq_count = 2'd0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (count !== 5'd0) $display("FAIL rst_count got=%0d exp=0", count);
    else n_pass++;
    n_chk++;
    if (free_slots !== 3'd4) $display("FAIL rst_free got=%0d exp=4", free_slots);
    else n_pass++;
    n_chk++;
    if (out_valid !== 2'b00) $display("FAIL rst_valid got=%b exp=00", out_valid);
    else n_pass++;
    n_chk++;
    if (overflow_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", overflow_err);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_enqueue();
    cycle(4, 0, 0);
    n_chk++;
    if (count !== 5'd4) $display("FAIL enq_count got=%0d exp=4", count);
    else n_pass++;
    n_chk++;
    if (out_valid !== 2'b11) $display("FAIL enq_valid got=%b exp=11", out_valid);
    else n_pass++;
    n_chk++;
    if (out_opcode[0] !== 4'd1 || out_opcode[1] !== 4'd2)
      $display("FAIL enq_opc got=%0d,%0d exp=1,2", out_opcode[0], out_opcode[1]);
    else n_pass++;
    n_chk++;
    if (free_slots !== 3'd4) $display("FAIL enq_free got=%0d exp=4", free_slots);
    else n_pass++;
  endtask

  task automatic test_simul();
    cycle(3, 2, 0);
    n_chk++;
    if (count !== 5'd5) $display("FAIL sim_count got=%0d exp=5", count);
    else n_pass++;
    n_chk++;
    if (out_opcode[0] !== 4'd3 || out_opcode[1] !== 4'd4)
      $display("FAIL sim_opc got=%0d,%0d exp=3,4", out_opcode[0], out_opcode[1]);
    else n_pass++;
    n_chk++;
    if (free_slots !== 3'd4) $display("FAIL sim_free got=%0d exp=4", free_slots);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    cycle(4, 0, 0);
    cycle(4, 0, 0);
    cycle(1, 0, 0);
    n_chk++;
    if (count !== 5'd14 || free_slots !== 3'd2)
      $display("FAIL fill14 got=%0d/%0d exp=14/2", count, free_slots);
    else n_pass++;
    n_chk++;
    if (overflow_err !== 1'b0) $display("FAIL fill_err0 got=%b exp=0", overflow_err);
    else n_pass++;
    cycle(3, 0, 0);
    n_chk++;
    if (overflow_err !== 1'b1 || count !== 5'd14)
      $display("FAIL ovf got=%b/%0d exp=1/14", overflow_err, count);
    else n_pass++;
    cycle(2, 0, 0);
    n_chk++;
    if (count !== 5'd16 || free_slots !== 3'd0)
      $display("FAIL full got=%0d/%0d exp=16/0", count, free_slots);
    else n_pass++;
    repeat (8) cycle(0, 2, 0);
    n_chk++;
    if (count !== 5'd0 || out_valid !== 2'b00)
      $display("FAIL drain got=%0d/%b exp=0/00", count, out_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    logic [3:0] nx;
    pop_log.delete();
    cycle(2, 0, 0);
    repeat (20) cycle(2, 2, 0);
    cycle(0, 2, 0);
    n_chk++;
    if (pop_log.size() != 42)
      $display("FAIL wrap_n got=%0d exp=42", pop_log.size());
    else n_pass++;
    for (int i = 1; i < pop_log.size(); i++) begin
      nx = pop_log[i-1] + 4'd1;
      if (pop_log[i] !== nx) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL wrap_order got=%0d breaks exp=0", bad);
    else n_pass++;
    n_chk++;
    if (count !== 5'd0) $display("FAIL wrap_count got=%0d exp=0", count);
    else n_pass++;
  endtask

  task automatic test_flush();
    cycle(4, 0, 0);
    cycle(4, 0, 0);
    cycle(1, 0, 0);
    n_chk++;
    if (count !== 5'd9) $display("FAIL pre_flush got=%0d exp=9", count);
    else n_pass++;
    cycle(4, 2, 1);
    n_chk++;
    if (count !== 5'd0 || out_valid !== 2'b00 || free_slots !== 3'd4)
      $display("FAIL flush got=%0d/%b/%0d exp=0/00/4",
               count, out_valid, free_slots);
    else n_pass++;
    n_chk++;
    if (overflow_err !== m_err)
      $display("FAIL flush_err got=%b exp=%b", overflow_err, m_err);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cycle(3, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (count !== 5'd0 || overflow_err !== 1'b0)
      $display("FAIL arst got=%0d/%b exp=0/0", count, overflow_err);
    else n_pass++;
    n_chk++;
    if (free_slots !== 3'd4 || out_valid !== 2'b00)
      $display("FAIL arst_out got=%0d/%b exp=4/00", free_slots, out_valid);
    else n_pass++;
    #2 rst_n = 1'b1;
    sb.delete();
    m_free = 4;
    m_err  = 1'b0;
    cycle(2, 0, 0);
    n_chk++;
    if (count !== 5'd2 || out_opcode[0] !== sb[0].opcode)
      $display("FAIL post_rst got=%0d/%0d exp=2/%0d",
               count, out_opcode[0], sb[0].opcode);
    else n_pass++;
  endtask

  task automatic test_deq_underflow();
    cycle(0, 2, 0);
    n_chk++;
    if (overflow_err !== 1'b0) $display("FAIL deq_ok_err got=%b exp=0", overflow_err);
    else n_pass++;
    cycle(0, 1, 0);
    n_chk++;
    if (overflow_err !== 1'b1 || count !== 5'd0)
      $display("FAIL deq_excess got=%b/%0d exp=1/0", overflow_err, count);
    else n_pass++;
  endtask

`ifdef IB_BYPASS_EN
  task automatic test_bypass();
    for (int k = 0; k < 4; k++) begin
      in_opcode[k] = 4'(k + 9);
    end
    in_count  = 3'd2;
    deq_count = 2'd2;
    #1;
    n_chk++;
    if (out_valid !== 2'b11) $display("FAIL byp_valid got=%b exp=11", out_valid);
    else n_pass++;
    n_chk++;
    if (out_opcode[0] !== 4'd9 || out_opcode[1] !== 4'd10)
      $display("FAIL byp_opc got=%0d,%0d exp=9,10", out_opcode[0], out_opcode[1]);
    else n_pass++;
    @(posedge clk);
    #1;
    in_count  = 3'd0;
    deq_count = 2'd0;
    n_chk++;
    if (count !== 5'd0) $display("FAIL byp_count got=%0d exp=0", count);
    else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    in_opcode = '0; in_rt = '0; in_ra = '0; in_rb = '0;
    in_a_owner = '0; in_b_owner = '0;
    in_a_dep = '0; in_b_dep = '0;
    test_reset();
    test_enqueue();
    test_simul();
    test_fill_overflow();
    test_wrap();
    test_flush();
    test_async_reset();
    test_deq_underflow();
`ifdef IB_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
